// File: rtl/multi_sync_filter.sv
// multi_sync_filter
//   Brings NUM_CH asynchronous single-bit signals into the clk_clkin domain.
//   Each channel has a STAGES-deep synchroniser followed by a stability filter.
//   A new value must be seen on FILT_CYCLES consecutive qualified samples
//   (sample_en=1) before it is committed to level_out. Each commit also raises
//   a one-cycle rise/fall pulse.
//
// Ports
//   clk_clkin  in   destination-domain clock
//   reset_n    in   asynchronous active-low reset
//   sig_in     in   [NUM_CH] asynchronous inputs
//   sample_en  in   filter sample strobe (tie 1 to filter on every cycle)
//   level_out  out  [NUM_CH] filtered synchronised level
//   rise_out   out  [NUM_CH] one-cycle pulse on a committed 0->1 change
//   fall_out   out  [NUM_CH] one-cycle pulse on a committed 1->0 change
//   any_change out  OR of all rise_out and fall_out bits

// Per-channel synchroniser and filter.
module multi_sync_filter_lane #(
   parameter int unsigned STAGES      = 3,
   parameter int unsigned FILT_CYCLES = 4,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   input  logic sample_en_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned      CW       = $clog2(FILT_CYCLES + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(FILT_CYCLES - 1);

   // Pure flop chain: only the last stage fans out to the filter.
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   logic          s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= {STAGES{RESET_VAL}};
      else         sync_q <= {sync_q[STAGES-2:0], sig_i};
   end

   assign s = sync_q[STAGES-1];

   // A qualified sample equal to the committed level restarts the count, so
   // only an unbroken run of differing samples can commit. Unqualified
   // cycles leave the count untouched.
   always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sample_en_i) begin
         if (s == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            lvl_d  = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         lvl_q  <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level_o = lvl_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

module multi_sync_filter #(
   parameter int unsigned       NUM_CH      = 2,
   parameter int unsigned       STAGES      = 3,
   parameter int unsigned       FILT_CYCLES = 4,
   parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
   input  logic              clk_clkin,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] sig_in,
   input  logic              sample_en,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] rise_out,
   output logic [NUM_CH-1:0] fall_out,
   output logic              any_change
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      multi_sync_filter_lane #(
         .STAGES      (STAGES),
         .FILT_CYCLES (FILT_CYCLES),
         .RESET_VAL   (RESET_VAL[g])
      ) u_lane (
         .clk_i       (clk_clkin),
         .rst_ni      (reset_n),
         .sig_i       (sig_in[g]),
         .sample_en_i (sample_en),
         .level_o     (level_out[g]),
         .rise_o      (rise_out[g]),
         .fall_o      (fall_out[g])
      );
   end

   assign any_change = |(rise_out | fall_out);

endmodule

// File: tb/tb_multi_sync_filter.sv
`timescale 1ns/100ps
module tb_multi_sync_filter;

   localparam int STG  = 3;
   localparam int FILT = 4;

   typedef struct {
      int         at;
      logic [1:0] rise;
      logic [1:0] fall;
      logic [1:0] lvl;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: defaults, used for latency, glitch, strobe, mid-count reset, stress
   logic       rst_a, se_a = 1'b1;
   logic [1:0] sig_a, lvl_a, rise_a, fall_a;
   logic       any_a;
   // DUT R: RESET_VAL = 2'b10
   logic       rst_r;
   logic [1:0] sig_r, lvl_r, rise_r, fall_r;
   logic       any_r;
   // DUT M: 8 channels, 2 stages, no filtering
   logic [7:0] sig_m, lvl_m, rise_m, fall_m;
   logic       any_m;

   multi_sync_filter dut_a (
      .clk_clkin(clk), .reset_n(rst_a), .sig_in(sig_a), .sample_en(se_a),
      .level_out(lvl_a), .rise_out(rise_a), .fall_out(fall_a), .any_change(any_a));

   multi_sync_filter #(.RESET_VAL(2'b10)) dut_r (
      .clk_clkin(clk), .reset_n(rst_r), .sig_in(sig_r), .sample_en(1'b1),
      .level_out(lvl_r), .rise_out(rise_r), .fall_out(fall_r), .any_change(any_r));

   multi_sync_filter #(.NUM_CH(8), .STAGES(2), .FILT_CYCLES(1)) dut_m (
      .clk_clkin(clk), .reset_n(rst_r), .sig_in(sig_m), .sample_en(1'b1),
      .level_out(lvl_m), .rise_out(rise_m), .fall_out(fall_m), .any_change(any_m));

   int         n_asrt = 0;
   int         n_fail = 0;
   int         ecnt   = 0;
   logic [1:0] hist [64];
   logic [1:0] prev_lvl = '0;
   logic       strobe_mode = 1'b0;
   logic       sb_on = 1'b0;
   logic       stress_on = 1'b0;
   exp_t       sbq [$];
   exp_t       ex;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int at, input logic [1:0] r, input logic [1:0] f, input logic [1:0] l);
      exp_t e;
      e.at = at; e.rise = r; e.fall = f; e.lvl = l;
      sbq.push_back(e);
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Edge counter and input history (value seen by the sync chain at each edge).
   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      hist[(ecnt + 1) % 64] <= sig_a;
   end

   // Strobe generator: in strobe mode only every 10th edge is qualified.
   always @(negedge clk)
      se_a <= strobe_mode ? (((ecnt + 1) % 10) == 0) : 1'b1;

   // Always-on checks plus scoreboard and stress monitors for DUT A.
   always @(negedge clk) begin
      logic ok;
      chk("rise_fall_excl", 32'(rise_a & fall_a), 32'd0);
      chk("any_change", 32'(any_a), 32'(|(rise_a | fall_a)));
      if (sb_on) begin
         if (sbq.size() != 0 && sbq[0].at < ecnt) begin
            chk("missed_pulse_at", ecnt, sbq[0].at);
            void'(sbq.pop_front());
         end
         if ((rise_a | fall_a) != 2'b00) begin
            if (sbq.size() == 0) chk("unexpected_pulse", {rise_a, fall_a}, 32'd0);
            else begin
               ex = sbq.pop_front();
               chk("pulse_cycle", ecnt, ex.at);
               chk("pulse_rise", 32'(rise_a), 32'(ex.rise));
               chk("pulse_fall", 32'(fall_a), 32'(ex.fall));
               chk("pulse_level", 32'(lvl_a), 32'(ex.lvl));
            end
         end
      end
      if (stress_on) begin
         for (int c = 0; c < 2; c++) begin
            logic chg;
            chg = lvl_a[c] ^ prev_lvl[c];
            chk("stress_rise", 32'(rise_a[c]), 32'(chg & lvl_a[c]));
            chk("stress_fall", 32'(fall_a[c]), 32'(chg & ~lvl_a[c]));
            if (chg) begin
               ok = 1'b1;
               for (int j = 0; j < FILT; j++)
                  if (hist[(ecnt - STG - j) % 64][c] !== lvl_a[c]) ok = 1'b0;
               chk("stress_stable_run", 32'(ok), 32'd1);
            end
         end
      end
      prev_lvl <= lvl_a;
   end

   initial begin
      int e0, k, m, cd [2];
      rst_a = 1'b0; rst_r = 1'b0;
      sig_a = 2'b00; sig_r = 2'b10; sig_m = 8'h00;
      wait_edges(3);

      // reset state
      chk("rst_lvl_a", 32'(lvl_a), 32'h0);
      chk("rst_lvl_r", 32'(lvl_r), 32'h2);
      chk("rst_pulse_r", 32'({rise_r, fall_r, any_r}), 32'h0);
      chk("rst_lvl_m", 32'(lvl_m), 32'h0);
      rst_a = 1'b1; rst_r = 1'b1; sb_on = 1'b1;

      // RESET_VAL held with matching input, no pulses
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_lvl_r", 32'(lvl_r), 32'h2);
         chk("hold_pulse_r", 32'({rise_r, fall_r, any_r}), 32'h0);
      end

      // latency: commit at edge k+6
      e0 = ecnt; sig_a[0] = 1'b1;
      push(e0 + 7, 2'b01, 2'b00, 2'b01);
      wait_edges(6);
      chk("lat_lvl_before", 32'(lvl_a[0]), 32'd0);
      wait_edges(1);
      chk("lat_lvl", 32'(lvl_a[0]), 32'd1);
      chk("lat_rise", 32'(rise_a), 32'h1);
      chk("lat_fall", 32'(fall_a), 32'h0);
      chk("lat_any", 32'(any_a), 32'd1);
      wait_edges(1);
      chk("lat_rise_end", 32'(rise_a), 32'h0);
      chk("lat_any_end", 32'(any_a), 32'd0);
      wait_edges(5);
      e0 = ecnt; sig_a[0] = 1'b0;
      push(e0 + 7, 2'b00, 2'b01, 2'b00);
      wait_edges(12);

      // glitch reject: 3 samples high never commits
      sig_a[1] = 1'b1; wait_edges(3); sig_a[1] = 1'b0;
      wait_edges(10);
      chk("glitch_lvl", 32'(lvl_a[1]), 32'd0);
      // 4 samples high commits, and the return low commits 4 cycles later
      e0 = ecnt; sig_a[1] = 1'b1;
      push(e0 + 7, 2'b10, 2'b00, 2'b10);
      push(e0 + 11, 2'b00, 2'b10, 2'b00);
      wait_edges(4); sig_a[1] = 1'b0;
      wait_edges(12);
      chk("glitch_lvl_end", 32'(lvl_a), 32'h0);

      // strobe gating: commit on the 4th strobe after s[0] goes high
      strobe_mode = 1'b1;
      wait_edges(3);
      e0 = ecnt; sig_a[0] = 1'b1;
      k = e0 + 1; m = k + STG;
      while (m % 10 != 0) m++;
      push(m + 30, 2'b01, 2'b00, 2'b01);
      wait_edges(m + 29 - ecnt);
      chk("strobe_lvl_before", 32'(lvl_a[0]), 32'd0);
      wait_edges(1);
      chk("strobe_lvl", 32'(lvl_a[0]), 32'd1);
      wait_edges(5);
      strobe_mode = 1'b0;
      wait_edges(3);

      // asynchronous reset in the middle of a count
      sig_a = 2'b11;
      wait_edges(4);
      #1 rst_a = 1'b0;
      #1;
      chk("async_rst_lvl", 32'(lvl_a), 32'h0);
      chk("async_rst_pulse", 32'({rise_a, fall_a, any_a}), 32'h0);
      @(negedge clk);
      rst_a = 1'b1;
      push(ecnt + 7, 2'b11, 2'b00, 2'b11);
      wait_edges(10);
      chk("post_rst_lvl", 32'(lvl_a), 32'h3);

      // multi-channel, no filtering
      sig_m = 8'hA5;
      wait_edges(2);
      chk("m_rise_early", 32'(rise_m), 32'h0);
      wait_edges(1);
      chk("m_rise", 32'(rise_m), 32'hA5);
      chk("m_fall", 32'(fall_m), 32'h0);
      chk("m_lvl", 32'(lvl_m), 32'hA5);
      chk("m_any", 32'(any_m), 32'd1);
      wait_edges(1);
      chk("m_rise_end", 32'(rise_m), 32'h0);
      chk("m_any_end", 32'(any_m), 32'd0);
      sig_m = 8'h0F;
      wait_edges(3);
      chk("m2_rise", 32'(rise_m), 32'h0A);
      chk("m2_fall", 32'(fall_m), 32'hA0);
      chk("m2_lvl", 32'(lvl_m), 32'h0F);
      wait_edges(1);
      chk("m2_pulse_end", 32'({rise_m, fall_m}), 32'h0);

      // async stress on DUT A, inputs on an unrelated 7 ns grid
      chk("sb_drain", sbq.size(), 32'd0);
      sb_on = 1'b0; stress_on = 1'b1;
      cd[0] = 1; cd[1] = 3;
      #0.3;
      for (int n = 0; n < 20000; n++) begin
         for (int c = 0; c < 2; c++) begin
            cd[c]--;
            if (cd[c] == 0) begin
               sig_a[c] = ~sig_a[c];
               cd[c] = $urandom_range(1, 20);
            end
         end
         #7;
      end
      wait_edges(20);
      chk("stress_final_lvl", 32'(lvl_a), 32'(sig_a));
      stress_on = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
